// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one 8-function ALU among NREQ requesters.
// Accepts one request, executes it on the next edge, holds the result until taken.
module alu_rr_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [IDW-1:0]         resp_id,
    output logic                   resp_carry,
    output logic                   resp_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   grant_inc;
    logic [IDW:0]     idx_sum;
    logic [IDW:0]     inc_sum;
    logic             found;
    logic             accept;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (idx_sum >= (IDW+1)'(NREQ)) begin
                idx_sum = idx_sum - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx_sum[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        inc_sum   = {1'b0, grant} + (IDW+1)'(1);
        grant_inc = inc_sum[IDW-1:0];
        if (inc_sum >= (IDW+1)'(NREQ)) begin
            grant_inc = '0;
        end
    end

    assign accept = rst_n && (state == IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_op[3*grant +: 3];
            a_q  <= req_a[WIDTH*grant +: WIDTH];
            b_q  <= req_b[WIDTH*grant +: WIDTH];
            id_q <= grant;
        end
    end

    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
            end
            3'b001: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = ~diff_w[WIDTH];
            end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = ~(a_q & b_q);
            3'b110: alu_res = ~(a_q | b_q);
            3'b111: alu_res = ~(a_q ^ b_q);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_carry <= 1'b0;
            resp_zero  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= grant_inc;
            end
            if (state == EXEC) begin
                resp_valid <= 1'b1;
                resp_data  <= alu_res;
                resp_id    <= id_q;
                resp_carry <= alu_carry;
                resp_zero  <= (alu_res == '0);
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer (WIDTH=8, NREQ=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_rr_sequencer;

    localparam int WIDTH = 8;
    localparam int NREQ = 4;
    localparam int IDW = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;
    logic                  resp_carry;
    logic                  resp_zero;

    int n_tests;
    int n_fail;

    alu_rr_sequencer #(
        .WIDTH(WIDTH),
        .NREQ(NREQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_id(resp_id),
        .resp_carry(resp_carry),
        .resp_zero(resp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[3*id +: 3]         = op;
        req_a[WIDTH*id +: WIDTH]  = a;
        req_b[WIDTH*id +: WIDTH]  = b;
    endtask

    // Starts at a falling edge with the DUT idle; ends idle again.
    task automatic do_op(input string tag, input int id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ec,
                         input logic ez);
        set_req(id, op, a, b);
        req_valid = 4'(1 << id);
        resp_ready = 1'b1;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        #1;
        check({tag, " exec valid"}, 32'(resp_valid), 0);
        check({tag, " exec ready"}, 32'(req_ready), 0);
        @(negedge clk);
        check({tag, " valid"}, 32'(resp_valid), 1);
        check({tag, " data"}, 32'(resp_data), 32'(ed));
        check({tag, " carry"}, 32'(resp_carry), 32'(ec));
        check({tag, " zero"}, 32'(resp_zero), 32'(ez));
        check({tag, " id"}, 32'(resp_id), 32'(id));
        @(negedge clk);
        check({tag, " drop"}, 32'(resp_valid), 0);
    endtask

    initial begin
        logic [7:0] held;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req_valid = '1;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst ready", 32'(req_ready), 0);
        check("rst valid", 32'(resp_valid), 0);
        check("rst data", 32'(resp_data), 0);
        check("rst id", 32'(resp_id), 0);
        check("rst carry", 32'(resp_carry), 0);
        check("rst zero", 32'(resp_zero), 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add", 0, 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        do_op("sub eq", 2, 3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        do_op("sub lt", 2, 3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        do_op("nand", 1, 3'b101, 8'hAA, 8'h0F, 8'hF5, 1'b0, 1'b0);
        do_op("nor", 1, 3'b110, 8'hAA, 8'h0F, 8'h50, 1'b0, 1'b0);
        do_op("xnor", 1, 3'b111, 8'hAA, 8'h0F, 8'h5A, 1'b0, 1'b0);
        do_op("and", 1, 3'b010, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0);
        do_op("or", 1, 3'b011, 8'h3C, 8'h0F, 8'h3F, 1'b0, 1'b0);

        // Backpressure: result must hold while req0 waits unserved.
        set_req(3, 3'b100, 8'h3C, 8'h0F);
        set_req(0, 3'b000, 8'h01, 8'h01);
        req_valid = 4'b1000;
        resp_ready = 1'b0;
        #1;
        check("bp ready3", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("bp exec ready", 32'(req_ready), 0);
        @(negedge clk);
        check("bp valid", 32'(resp_valid), 1);
        check("bp data", 32'(resp_data), 32'h33);
        check("bp id", 32'(resp_id), 3);
        held = resp_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold valid", 32'(resp_valid), 1);
            check("bp hold data", 32'(resp_data), 32'(held));
            check("bp hold id", 32'(resp_id), 3);
            check("bp hold ready", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp released", 32'(resp_valid), 0);
        check("bp next ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("bp2 data", 32'(resp_data), 32'h02);
        check("bp2 id", 32'(resp_id), 0);
        @(negedge clk);

        // Reset in EXEC; rr_ptr would be 3 if the reset were ignored.
        set_req(2, 3'b000, 8'h11, 8'h22);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst valid", 32'(resp_valid), 0);
        req_valid = '1;
        #1;
        check("mid rst ready", 32'(req_ready), 0);
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no stale", 32'(resp_valid), 0);
        end

        // Fairness with all requesters held valid.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 3'b000, 8'(i), 8'h40);
        end
        req_valid = '1;
        resp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr grant", 32'(req_ready), 32'(1 << (n % NREQ)));
            @(negedge clk);
            check("rr exec ready", 32'(req_ready), 0);
            @(negedge clk);
            check("rr resp ready", 32'(req_ready), 0);
            check("rr id", 32'(resp_id), 32'(n % NREQ));
            check("rr data", 32'(resp_data), 32'h40 + 32'(n % NREQ));
            @(negedge clk);
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
